// File: rtl/cbd_poly_writer.sv
// cbd_poly_writer: maps eta=3 CBD beats into [0,Q) and writes one polynomial to RAM
module cbd_poly_writer #(
  parameter int Q       = 3329,
  parameter int ETA     = 3,
  parameter int N_COEFF = 256,
  parameter int LANES   = 4,
  parameter int ADDR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            poly_sel,
  input  logic                  in_valid,
  input  logic [12*LANES-1:0]   in_coeffs,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [12*LANES-1:0]   mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err
);
  localparam int WORDS = N_COEFF / LANES;
  localparam int CW = $clog2(WORDS);
  localparam logic signed [11:0] ETA_S = 12'(ETA);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] base_q, base_d;
  logic err_q, err_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [12*LANES-1:0] wdata_q, wdata_d, wdata_map;
  logic [11:0] c;
  logic lane_bad, accept, last;
  assign accept = (state_q == RUN) && in_valid;
  assign last = cnt_q == CW'(WORDS - 1);
  assign in_ready = state_q == RUN;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign range_err = err_q;
  // per-lane modular lift of negative coefficients and out-of-range detection
  always_comb begin
    wdata_map = '0;
    lane_bad = 1'b0;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = in_coeffs[12*i +: 12];
      wdata_map[12*i +: 12] = c[11] ? c + 12'(Q) : c;
      lane_bad = lane_bad | ($signed(c) > ETA_S) | ($signed(c) < -ETA_S);
    end
  end
  // next-state: sequencing, beat counting, and the one-cycle write pipeline
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    cnt_d = cnt_q;
    err_d = err_q;
    we_d = accept;
    addr_d = accept ? ADDR_W'({base_q, cnt_q}) : addr_q;
    wdata_d = accept ? wdata_map : wdata_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        base_d = poly_sel;
        cnt_d = '0;
        err_d = 1'b0;
      end
      RUN: if (accept) begin
        cnt_d = last ? cnt_q : cnt_q + CW'(1);
        err_d = err_q | lane_bad;
        state_d = last ? FLUSH : RUN;
      end
      FLUSH: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset that aborts any pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_cbd_poly_writer.sv
// tb_cbd_poly_writer: directed table-driven checks of the CBD polynomial writer
module tb_cbd_poly_writer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [1:0] poly_sel = 2'd0;
  logic [47:0] in_coeffs = '0;
  logic in_ready, mem_we, busy, done, range_err;
  logic [7:0] mem_addr;
  logic [47:0] mem_wdata;
  int checks = 0, errors = 0;

  typedef struct {
    logic [1:0]  sel;
    bit          gap;
    bit          noisy;
    logic [47:0] coeffs;
    logic [47:0] wdata;
    logic        err;
  } vec_t;
  vec_t vecs [7];

  cbd_poly_writer dut (
    .clk(clk), .reset(reset), .start(start), .poly_sel(poly_sel),
    .in_valid(in_valid), .in_coeffs(in_coeffs), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " in_ready"}, 64'(in_ready), 0);
    chk({tag, " mem_we"}, 64'(mem_we), 0);
    chk({tag, " busy"}, 64'(busy), 0);
    chk({tag, " done"}, 64'(done), 0);
  endtask

  task automatic run_poly(input int k);
    vec_t v;
    int cyc, nw, nb;
    v = vecs[k];
    @(negedge clk);
    start = 1'b1;
    poly_sel = v.sel;
    @(negedge clk);
    start = 1'b0;
    poly_sel = ~v.sel;
    chk($sformatf("v%0d busy after start", k), 64'(busy), 1);
    chk($sformatf("v%0d in_ready in RUN", k), 64'(in_ready), 1);
    chk($sformatf("v%0d range_err cleared", k), 64'(range_err), 0);
    cyc = 0; nw = 0; nb = 0;
    while (cyc < 400) begin
      if (mem_we) begin
        chk($sformatf("v%0d addr #%0d", k, nw), 64'(mem_addr), 64'({v.sel, nw[5:0]}));
        chk($sformatf("v%0d wdata #%0d", k, nw), 64'(mem_wdata), 64'(v.wdata));
        nw++;
      end
      if (nw == 64) break;
      start = v.noisy && cyc == 10;
      in_valid = (nb < 64 || v.noisy) && (!v.gap || cyc[0] == 1'b0);
      in_coeffs = v.coeffs;
      if (in_valid && in_ready) nb++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("v%0d writes", k), 64'(nw), 64);
    chk($sformatf("v%0d last write cycle", k), 64'(cyc), v.gap ? 127 : 64);
    chk($sformatf("v%0d FLUSH in_ready", k), 64'(in_ready), 0);
    chk($sformatf("v%0d FLUSH busy", k), 64'(busy), 1);
    chk($sformatf("v%0d FLUSH done", k), 64'(done), 0);
    @(negedge clk);
    chk($sformatf("v%0d DONE done", k), 64'(done), 1);
    chk($sformatf("v%0d DONE mem_we", k), 64'(mem_we), 0);
    chk($sformatf("v%0d DONE in_ready", k), 64'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk_idle($sformatf("v%0d after", k));
    @(negedge clk);
    chk_idle($sformatf("v%0d idle", k));
    chk($sformatf("v%0d range_err", k), 64'(range_err), 64'(v.err));
  endtask

  initial begin
    vecs[0] = '{2'd1, 1'b0, 1'b0, 48'h003_002_001_000, 48'h003_002_001_000, 1'b0};
    vecs[1] = '{2'd0, 1'b0, 1'b0, 48'h003_FFE_FFF_FFD, 48'h003_CFF_D00_CFE, 1'b0};
    vecs[2] = '{2'd3, 1'b1, 1'b0, 48'h000_000_000_004, 48'h000_000_000_004, 1'b1};
    vecs[3] = '{2'd2, 1'b0, 1'b1, 48'hFFC_000_000_000, 48'hCFD_000_000_000, 1'b1};
    vecs[4] = '{2'd0, 1'b0, 1'b0, 48'h000_000_000_000, 48'h000_000_000_000, 1'b0};
    vecs[5] = '{2'd1, 1'b1, 1'b1, 48'hFFD_FFD_FFD_FFD, 48'hCFE_CFE_CFE_CFE, 1'b0};
    vecs[6] = '{2'd2, 1'b0, 1'b0, 48'h800_7FF_001_FFF, 48'h501_7FF_001_D00, 1'b1};
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset range_err", 64'(range_err), 0);
    chk("reset mem_addr", 64'(mem_addr), 0);
    chk("reset mem_wdata", 64'(mem_wdata), 0);
    reset = 1'b0;
    for (int k = 0; k < 7; k++) run_poly(k);
    @(negedge clk);
    start = 1'b1;
    poly_sel = 2'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_coeffs = 48'h000_000_000_004;
    repeat (20) @(negedge clk);
    chk("mid busy", 64'(busy), 1);
    chk("mid range_err", 64'(range_err), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("abort");
    chk("abort range_err", 64'(range_err), 0);
    chk("abort mem_addr", 64'(mem_addr), 0);
    chk("abort mem_wdata", 64'(mem_wdata), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post-abort idle %0d", i), 64'({mem_we, in_ready, busy}), 0);
    end
    in_valid = 1'b0;
    run_poly(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
